// File: rtl/timer_ctrl.sv
// timer_ctrl: start/pause/clear/alarm sequencer for an external up-counter.
// It turns debounced key levels into single-cycle rising-edge events. It
// enables the timer while running, raises a timed alarm when the count
// expires, and issues a one-cycle clear to the timer whenever the sequencer
// returns to IDLE through a clear key press or the end of the alarm.
module timer_ctrl #(
  parameter int TIME_SET     = 99,
  parameter int ALARM_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       timeup,
  input  logic [7:0] count_time,
  output logic       timer_en,
  output logic       timer_clr,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0]  TIME_SET_V = 8'(TIME_SET);
  localparam logic [25:0] ALARM_LAST = 26'(ALARM_CYCLES - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic        nxt_clr;
  logic        key_start_q;
  logic        key_clear_q;
  logic [25:0] alarm_cnt;

  logic start_edge;
  logic clear_edge;
  logic expired;
  logic alarm_done;

  // Only rising edges of the key levels act. The level registers reset high,
  // so a key held through reset release is not seen as a press.
  assign start_edge = key_start & ~key_start_q;
  assign clear_edge = key_clear & ~key_clear_q;
  assign expired    = timeup | (count_time == TIME_SET_V);
  assign alarm_done = (alarm_cnt == ALARM_LAST);
  assign state      = cur_state;

  // Next-state selection: clear beats everything, and expiry beats pause in RUN.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    nxt_state = cur_state;
    nxt_clr   = 1'b0;
    if (clear_edge) begin
      nxt_state = IDLE;
      nxt_clr   = 1'b1;
    end else begin
      case (cur_state)
        IDLE:    if (start_edge) nxt_state = RUN;
        RUN: begin
          if (expired)         nxt_state = ALARM;
          else if (start_edge) nxt_state = PAUSE;
        end
        PAUSE:   if (start_edge) nxt_state = RUN;
        ALARM: begin
          if (alarm_done) begin
            nxt_state = IDLE;
            nxt_clr   = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // State, key history, alarm counter and outputs, all decoded from the next
  // state so that the outputs change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= IDLE;
      key_start_q <= 1'b1;
      key_clear_q <= 1'b1;
      alarm_cnt   <= '0;
      timer_en    <= 1'b0;
      timer_clr   <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the pre-edge values regardless of statement order.
      cur_state   <= nxt_state;
      key_start_q <= key_start;
      key_clear_q <= key_clear;
      // The counter restarts at 0 on entry to ALARM and is held at 0 elsewhere.
      // It stops at ALARM_LAST because ALARM is left on that same edge.
      if (cur_state == ALARM && nxt_state == ALARM) alarm_cnt <= alarm_cnt + 26'd1;
      else                                          alarm_cnt <= '0;
      timer_en    <= (nxt_state == RUN);
      alarm       <= (nxt_state == ALARM);
      timer_clr   <= nxt_clr;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scenario tests for timer_ctrl with TIME_SET=5, ALARM_CYCLES=4.
// Each driven cycle pushes its expected {state, timer_en, timer_clr, alarm}
// onto a scoreboard queue. That entry is popped and compared once the DUT has
// responded at the following clock edge.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start = 1'b0;
  logic       key_clear = 1'b0;
  logic       timeup = 1'b0;
  logic [7:0] count_time = 8'd0;
  logic       timer_en;
  logic       timer_clr;
  logic       alarm;
  logic [1:0] state;

  logic [4:0] got;
  logic [4:0] sb [$];
  int total = 0;
  int bad   = 0;

  // Expected output vectors {state[1:0], timer_en, timer_clr, alarm}.
  localparam logic [4:0] E_IDLE  = 5'b00_0_0_0;
  localparam logic [4:0] E_CLR   = 5'b00_0_1_0;
  localparam logic [4:0] E_RUN   = 5'b01_1_0_0;
  localparam logic [4:0] E_PAUSE = 5'b10_0_0_0;
  localparam logic [4:0] E_ALARM = 5'b11_0_0_1;

  timer_ctrl #(.TIME_SET(5), .ALARM_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .key_clear  (key_clear),
    .timeup     (timeup),
    .count_time (count_time),
    .timer_en   (timer_en),
    .timer_clr  (timer_clr),
    .alarm      (alarm),
    .state      (state)
  );

  assign got = {state, timer_en, timer_clr, alarm};

  always #5 clk = ~clk;

  // Stimulus word {key_start, key_clear, timeup, count_time}.
  function automatic logic [10:0] mk(input int ks, input int kc, input int tu, input int ct);
    return {ks[0], kc[0], tu[0], ct[7:0]};
  endfunction

  task automatic test_reset();
    logic [10:0] stim [14];
    logic [4:0]  want [14];
    logic [4:0]  e;
    key_start = 1'b1;
    key_clear = 1'b1;
    #2 rst = 1'b1;
    #1;
    sb.push_back(E_IDLE);
    e = sb.pop_front();
    total++;
    if (got !== e) begin bad++; $display("FAIL reset_async: got=%b want=%b", got, e); end
    @(posedge clk); #1;
    sb.push_back(E_IDLE);
    e = sb.pop_front();
    total++;
    if (got !== e) begin bad++; $display("FAIL reset_held: got=%b want=%b", got, e); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stim[i] = mk(1, 1, 0, 0);
      want[i] = E_IDLE;
    end
    stim[10] = mk(0, 1, 0, 0); want[10] = E_IDLE;
    stim[11] = mk(1, 1, 0, 0); want[11] = E_RUN;
    stim[12] = mk(0, 0, 0, 0); want[12] = E_RUN;
    stim[13] = mk(0, 1, 0, 0); want[13] = E_CLR;
    for (int i = 0; i < 14; i++) begin
      {key_start, key_clear, timeup, count_time} = stim[i];
      sb.push_back(want[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL reset[%0d]: got=%b want=%b", i, got, e); end
    end
  endtask

  task automatic test_pause();
    logic [10:0] stim [12];
    logic [4:0]  want [12];
    logic [4:0]  e;
    stim = '{mk(0,0,0,0), mk(1,0,0,0), mk(0,0,0,0), mk(1,0,0,0), mk(1,0,0,0), mk(0,0,0,0),
             mk(0,0,1,5), mk(1,0,0,0), mk(0,0,0,0), mk(0,1,0,0), mk(0,0,0,0), mk(0,1,0,0)};
    want = '{E_IDLE, E_RUN, E_RUN, E_PAUSE, E_PAUSE, E_PAUSE,
             E_PAUSE, E_RUN, E_RUN, E_CLR, E_IDLE, E_CLR};
    for (int i = 0; i < 12; i++) begin
      {key_start, key_clear, timeup, count_time} = stim[i];
      sb.push_back(want[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL pause[%0d]: got=%b want=%b", i, got, e); end
    end
  endtask

  task automatic test_alarm();
    logic [10:0] stim [10];
    logic [4:0]  want [10];
    logic [4:0]  e;
    stim = '{mk(0,0,0,0), mk(1,0,0,0), mk(0,0,0,0), mk(0,0,0,5), mk(0,0,0,5),
             mk(0,0,0,0), mk(1,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(0,0,1,5)};
    want = '{E_IDLE, E_RUN, E_RUN, E_ALARM, E_ALARM,
             E_ALARM, E_ALARM, E_CLR, E_IDLE, E_IDLE};
    for (int i = 0; i < 10; i++) begin
      {key_start, key_clear, timeup, count_time} = stim[i];
      sb.push_back(want[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL alarm[%0d]: got=%b want=%b", i, got, e); end
    end
  endtask

  task automatic test_exp_wins();
    logic [10:0] stim [6];
    logic [4:0]  want [6];
    logic [4:0]  e;
    stim = '{mk(0,0,0,0), mk(1,0,0,0), mk(0,0,0,0), mk(1,0,1,0), mk(0,1,0,0), mk(0,0,0,0)};
    want = '{E_IDLE, E_RUN, E_RUN, E_ALARM, E_CLR, E_IDLE};
    for (int i = 0; i < 6; i++) begin
      {key_start, key_clear, timeup, count_time} = stim[i];
      sb.push_back(want[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL exp_wins[%0d]: got=%b want=%b", i, got, e); end
    end
  endtask

  task automatic test_clear_priority();
    logic [10:0] stim [7];
    logic [4:0]  want [7];
    logic [4:0]  e;
    stim = '{mk(1,0,0,0), mk(0,0,1,0), mk(0,0,0,0), mk(1,1,0,0), mk(0,0,0,0),
             mk(1,1,0,0), mk(0,0,0,0)};
    want = '{E_RUN, E_ALARM, E_ALARM, E_CLR, E_IDLE, E_CLR, E_IDLE};
    for (int i = 0; i < 7; i++) begin
      {key_start, key_clear, timeup, count_time} = stim[i];
      sb.push_back(want[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL clear_prio[%0d]: got=%b want=%b", i, got, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] stim [7];
    logic [4:0]  want [7];
    logic [4:0]  e;
    stim = '{mk(1,0,0,0), mk(0,0,1,0), mk(0,0,0,0),
             mk(0,0,0,0), mk(0,0,0,0), mk(1,0,0,0), mk(0,0,0,0)};
    want = '{E_RUN, E_ALARM, E_ALARM, E_IDLE, E_IDLE, E_RUN, E_IDLE};
    for (int i = 0; i < 7; i++) begin
      {key_start, key_clear, timeup, count_time} = stim[i];
      sb.push_back(want[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL async_rst[%0d]: got=%b want=%b", i, got, e); end
      // Reset between edges, first mid-ALARM (step 2) and then mid-RUN (step 5).
      if (i == 2 || i == 5) begin
        #3 rst = 1'b1;
        #1;
        sb.push_back(E_IDLE);
        e = sb.pop_front();
        total++;
        if (got !== e) begin bad++; $display("FAIL async_rst_drop[%0d]: got=%b want=%b", i, got, e); end
        @(posedge clk); #1;
        sb.push_back(E_IDLE);
        e = sb.pop_front();
        total++;
        if (got !== e) begin bad++; $display("FAIL async_rst_hold[%0d]: got=%b want=%b", i, got, e); end
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_alarm();
    test_exp_wins();
    test_clear_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TIME_SET, default 99: terminal count of the controlled timer (0..255).
REQ-002 Parameter ALARM_CYCLES, default 50_000_000: alarm duration in clk cycles, range 1..2^26-1.
REQ-003 Port clk, input, 1: sole clock; all state changes on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port key_start, input, 1: debounced start/pause key level, active-high.
REQ-006 Port key_clear, input, 1: debounced clear key level, active-high.
REQ-007 Port timeup, input, 1: count_up flag from timer.
REQ-008 Port count_time, input, 8: current binary count from timer.
REQ-009 Port timer_en, output, 1: count enable to timer, registered.
REQ-010 Port timer_clr, output, 1: clear pulse to timer rst, registered.
REQ-011 Port alarm, output, 1: alarm indicator, registered.
REQ-012 Port state, output, 2: current state (IDLE=0, RUN=1, PAUSE=2, ALARM=3).

Function
REQ-013 Key edges: registered previous levels key_start_q, key_clear_q; start_edge = key_start & ~key_start_q; clear_edge = key_clear & ~key_clear_q; only rising edges act, held levels ignored.
REQ-014 Expiry condition exp = timeup | (count_time == TIME_SET).
REQ-015 IDLE: start_edge -> RUN; timeup/count_time ignored.
REQ-016 RUN: exp -> ALARM; else start_edge -> PAUSE.
REQ-017 PAUSE: start_edge -> RUN; exp ignored.
REQ-018 ALARM: 26-bit alarm counter loaded 0 on entry, incremented each cycle; on reaching ALARM_CYCLES-1 -> IDLE; start_edge ignored.
REQ-019 clear_edge in any state -> IDLE, highest priority over start_edge, exp and alarm expiry.
REQ-020 RUN with exp and start_edge in same cycle -> ALARM (exp wins).
REQ-021 Transitions take effect at the clk edge where the edge/condition is sampled; state, timer_en, alarm reflect new state after that same edge (zero extra latency, all registered).
REQ-022 timer_en = 1 exactly while state == RUN.
REQ-023 alarm = 1 exactly while state == ALARM; alarm high for exactly ALARM_CYCLES cycles when uninterrupted.
REQ-024 timer_clr = 1 for exactly one cycle following every transition into IDLE (clear_edge from any state incl. IDLE, or alarm expiry); 0 otherwise.
REQ-025 Re-entry RUN from PAUSE leaves timer count untouched (no timer_clr).
REQ-026 Alarm counter frozen at 0 outside ALARM; no wrap.

Reset
REQ-027 rst asserted: state=IDLE, timer_en=0, timer_clr=0, alarm=0, alarm counter=0, key_start_q=1, key_clear_q=1 (keys held through reset release produce no edge), immediately and asynchronously.
REQ-028 rst mid-RUN or mid-ALARM: outputs drop same instant; after release block waits in IDLE for a fresh start_edge.

Verification (ALARM_CYCLES=4, TIME_SET=5)
REQ-029 Reset release with key_start held 1 -> state stays 0, timer_en 0 for 10 cycles; release then press key_start -> state=1, timer_en=1 at next edge.
REQ-030 RUN, press key_start -> state=2, timer_en=0; press again -> state=1, timer_en=1, timer_clr never pulses.
REQ-031 RUN, drive count_time=5 -> state=3, timer_en=0, alarm=1 for exactly 4 cycles, then state=0 and timer_clr=1 for exactly 1 cycle.
REQ-032 RUN, timeup=1 and key_start rising same cycle -> state=3, not 2.
REQ-033 ALARM cycle 2, key_clear and key_start rising together -> state=0, alarm=0, timer_clr one-cycle pulse, no RUN.
REQ-034 rst asserted asynchronously mid-ALARM (between clk edges) -> alarm, timer_en, state=0 before next clk edge; timer_clr stays 0.
